// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS core: owns the fetch PC, selects the next PC from
// D-stage branch/jump controls and latches the fetched word into the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        beq_taken_i,
    input  logic        j_instr_i,
    input  logic        jr_i,
    input  logic [15:0] imm16_d_i,
    input  logic [25:0] imm26_d_i,
    input  logic [31:0] jr_target_i,
    output logic [9:0]  imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_f_o,
    output logic [31:0] ir_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc8_d_o,
    output logic        valid_d_o,
    output logic        fetch_err_o
);

    // Exclusive upper bound of the instruction memory, widened so it cannot wrap.
    localparam logic [32:0] IMEM_END = {1'b0, RESET_PC} + (33'(IMEM_WORDS) << 2);

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] ir_d_q, ir_d_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic        valid_d_q, valid_d_d;
    logic [31:0] npc;
    logic [31:0] branch_off;
    logic        fetch_err;

    assign branch_off = {{14{imm16_d_i[15]}}, imm16_d_i, 2'b00};

    always_comb begin
        npc = pc_f_q + 32'd4;
        if (jr_i) begin
            npc = jr_target_i;
        end else if (j_instr_i) begin
            npc = {pc_d_q[31:28], imm26_d_i, 2'b00};
        end else if (beq_taken_i) begin
            npc = pc_d_q + 32'd4 + branch_off;
        end
    end

    assign fetch_err = (pc_f_q[1:0] != 2'b00)
                     | (pc_f_q < RESET_PC)
                     | ({1'b0, pc_f_q} >= IMEM_END);

    assign imem_addr_o = pc_f_q[11:2] - RESET_PC[11:2];

    // A stalled cycle keeps everything; the D-stage redirect is simply re-evaluated later.
    always_comb begin
        pc_f_d    = pc_f_q;
        ir_d_d    = ir_d_q;
        pc_d_d    = pc_d_q;
        valid_d_d = valid_d_q;
        if (!stall_i) begin
            pc_f_d    = npc;
            ir_d_d    = fetch_err ? 32'h0 : imem_rdata_i;
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_f_q    <= RESET_PC;
            ir_d_q    <= 32'h0;
            pc_d_q    <= RESET_PC;
            valid_d_q <= 1'b0;
        end else begin
            pc_f_q    <= pc_f_d;
            ir_d_q    <= ir_d_d;
            pc_d_q    <= pc_d_d;
            valid_d_q <= valid_d_d;
        end
    end

    assign pc_f_o      = pc_f_q;
    assign ir_d_o      = ir_d_q;
    assign pc_d_o      = pc_d_q;
    assign pc8_d_o     = pc_d_q + 32'd8;
    assign valid_d_o   = valid_d_q;
    assign fetch_err_o = fetch_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, delay-slot redirects, stall,
// fetch range errors and asynchronous reset.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall;
    logic        beqTaken;
    logic        jInstr;
    logic        jr;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jrTarget;
    logic [9:0]  imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] pcF;
    logic [31:0] irD;
    logic [31:0] pcD;
    logic [31:0] pc8D;
    logic        validD;
    logic        fetchErr;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] imem [1024];

    always #5 clk = ~clk;

    assign imemRdata = imem[imemAddr];

    fetch_stage dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .stall_i      (stall),
        .beq_taken_i  (beqTaken),
        .j_instr_i    (jInstr),
        .jr_i         (jr),
        .imm16_d_i    (imm16),
        .imm26_d_i    (imm26),
        .jr_target_i  (jrTarget),
        .imem_addr_o  (imemAddr),
        .imem_rdata_i (imemRdata),
        .pc_f_o       (pcF),
        .ir_d_o       (irD),
        .pc_d_o       (pcD),
        .pc8_d_o      (pc8D),
        .valid_d_o    (validD),
        .fetch_err_o  (fetchErr)
    );

    // Instruction word stored at a byte address inside the memory image.
    function automatic logic [31:0] wordAt(input logic [31:0] addr);
        return 32'h1000_0000 | ((addr - 32'h3000) >> 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearControls();
        stall    = 1'b0;
        beqTaken = 1'b0;
        jInstr   = 1'b0;
        jr       = 1'b0;
        imm16    = 16'h0;
        imm26    = 26'h0;
        jrTarget = 32'h0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        clearControls();
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        doReset();
        nCompared++;
        if ({pcF, irD, pcD, validD} !== {32'h3000, 32'h0, 32'h3000, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_state got pc_f=%h ir_d=%h pc_d=%h valid=%b want 3000/0/3000/0",
                     pcF, irD, pcD, validD);
        end
        nCompared++;
        if ({pc8D, fetchErr, imemAddr} !== {32'h3008, 1'b0, 10'h0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_aux got pc8_d=%h err=%b addr=%h want 3008/0/000",
                     pc8D, fetchErr, imemAddr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] expPcF, expPcD;
        doReset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            expPcF = 32'h3000 + 32'(4 * k);
            expPcD = 32'h3000 + 32'(4 * (k - 1));
            nCompared++;
            if ({pcF, irD, pcD, validD} !== {expPcF, wordAt(expPcD), expPcD, 1'b1}) begin
                nMismatched++;
                $display("[TB] FAIL seq_%0d got pc_f=%h ir_d=%h pc_d=%h valid=%b want %h/%h/%h/1",
                         k, pcF, irD, pcD, validD, expPcF, wordAt(expPcD), expPcD);
            end
        end
    endtask

    task automatic test_beq_back();
        doReset();
        tick();
        tick();
        beqTaken = 1'b1;
        imm16    = 16'hFFFF;
        tick();
        beqTaken = 1'b0;
        imm16    = 16'h0;
        nCompared++;
        if ({pcF, irD, pcD} !== {32'h3004, wordAt(32'h3008), 32'h3008}) begin
            nMismatched++;
            $display("[TB] FAIL beq_slot got pc_f=%h ir_d=%h pc_d=%h want 3004/%h/3008",
                     pcF, irD, pcD, wordAt(32'h3008));
        end
        tick();
        nCompared++;
        if ({pcF, irD, pcD} !== {32'h3008, wordAt(32'h3004), 32'h3004}) begin
            nMismatched++;
            $display("[TB] FAIL beq_target got pc_f=%h ir_d=%h pc_d=%h want 3008/%h/3004",
                     pcF, irD, pcD, wordAt(32'h3004));
        end
    endtask

    task automatic test_jal();
        doReset();
        for (int k = 0; k < 5; k++) tick();
        nCompared++;
        if ({pcD, pc8D} !== {32'h3010, 32'h3018}) begin
            nMismatched++;
            $display("[TB] FAIL jal_pc8 got pc_d=%h pc8_d=%h want 3010/3018", pcD, pc8D);
        end
        jInstr = 1'b1;
        imm26  = 26'h0000C10;
        tick();
        jInstr = 1'b0;
        imm26  = 26'h0;
        nCompared++;
        if ({pcF, irD, pcD} !== {32'h3040, wordAt(32'h3014), 32'h3014}) begin
            nMismatched++;
            $display("[TB] FAIL jal_target got pc_f=%h ir_d=%h pc_d=%h want 3040/%h/3014",
                     pcF, irD, pcD, wordAt(32'h3014));
        end
    endtask

    task automatic test_stall_jr();
        doReset();
        tick();
        tick();
        jr       = 1'b1;
        jrTarget = 32'h3100;
        stall    = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            nCompared++;
            if ({pcF, irD, pcD, pc8D, validD} !==
                {32'h3008, wordAt(32'h3004), 32'h3004, 32'h300C, 1'b1}) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold_%0d got pc_f=%h ir_d=%h pc_d=%h pc8=%h valid=%b",
                         k, pcF, irD, pcD, pc8D, validD);
            end
        end
        stall = 1'b0;
        tick();
        jr = 1'b0;
        nCompared++;
        if ({pcF, irD, pcD, imemAddr} !== {32'h3100, wordAt(32'h3008), 32'h3008, 10'h040}) begin
            nMismatched++;
            $display("[TB] FAIL jr_release got pc_f=%h ir_d=%h pc_d=%h addr=%h want 3100/%h/3008/040",
                     pcF, irD, pcD, imemAddr, wordAt(32'h3008));
        end
    endtask

    task automatic test_fetch_err();
        // Continues from pc_f = 0x3100.
        jr       = 1'b1;
        jrTarget = 32'h3102;
        tick();
        jr = 1'b0;
        nCompared++;
        if (fetchErr !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL misalign_err got %b want 1", fetchErr);
        end
        tick();
        nCompared++;
        if ({pcF, irD, pcD, validD} !== {32'h3106, 32'h0, 32'h3102, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL misalign_nop got pc_f=%h ir_d=%h pc_d=%h valid=%b want 3106/0/3102/1",
                     pcF, irD, pcD, validD);
        end
        jr       = 1'b1;
        jrTarget = 32'h2FFC;
        tick();
        jr = 1'b0;
        nCompared++;
        if ({pcF, fetchErr} !== {32'h2FFC, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL below_err got pc_f=%h err=%b want 2ffc/1", pcF, fetchErr);
        end
        tick();
        nCompared++;
        if ({pcF, irD, pcD, validD, fetchErr} !== {32'h3000, 32'h0, 32'h2FFC, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL below_nop got pc_f=%h ir_d=%h pc_d=%h valid=%b err=%b want 3000/0/2ffc/1/0",
                     pcF, irD, pcD, validD, fetchErr);
        end
        jr       = 1'b1;
        jrTarget = 32'h3FFC;
        tick();
        nCompared++;
        if ({fetchErr, imemAddr} !== {1'b0, 10'h3FF}) begin
            nMismatched++;
            $display("[TB] FAIL last_word got err=%b addr=%h want 0/3ff", fetchErr, imemAddr);
        end
        jrTarget = 32'h4000;
        tick();
        jr = 1'b0;
        nCompared++;
        if ({pcF, irD, fetchErr} !== {32'h4000, wordAt(32'h3FFC), 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL above_err got pc_f=%h ir_d=%h err=%b want 4000/%h/1",
                     pcF, irD, fetchErr, wordAt(32'h3FFC));
        end
    endtask

    task automatic test_async_reset();
        doReset();
        tick();
        tick();
        tick();
        stall = 1'b1;
        @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        nCompared++;
        if ({pcF, irD, pcD, validD} !== {32'h3000, 32'h0, 32'h3000, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL async_reset got pc_f=%h ir_d=%h pc_d=%h valid=%b want 3000/0/3000/0",
                     pcF, irD, pcD, validD);
        end
        @(negedge clk);
        stall = 1'b0;
        rstN  = 1'b1;
        tick();
        nCompared++;
        if ({pcF, irD, pcD, validD} !== {32'h3004, wordAt(32'h3000), 32'h3000, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_fetch got pc_f=%h ir_d=%h pc_d=%h valid=%b",
                     pcF, irD, pcD, validD);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 | 32'(i);
        rstN = 1'b0;
        clearControls();
        test_reset();
        test_sequential();
        test_beq_back();
        test_jal();
        test_stall_jr();
        test_fetch_err();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before tests completed");
        $fatal(1, "[TB] timeout");
    end

endmodule
